sck_alu_sequencer: RTL and testbench

Command-side front end for the 10-bit signed SCK ALU. The block accepts operation requests over a valid/ready command channel and drives the ALU's operand and opcode inputs from registers. It captures the ALU's combinational result and flags, then returns them over a valid/ready response channel. It sits between the system controller or testbench stimulus and the ALU, and keeps a saturating overflow statistic.

---
 rtl/sck_alu_pkg.sv | 26 ++
 rtl/sck_sat_counter.sv | 27 ++
 rtl/sck_alu_sequencer.sv | 103 ++++++++++
 tb/tb_sck_alu_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/sck_alu_pkg.sv
// sck_alu_pkg: shared width, opcode, flag-index and FSM-state definitions for the SCK ALU front end
package sck_alu_pkg;

    localparam int DATA_W = 10;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_SHL  = 3'd2;
    localparam logic [2:0] OP_SHR  = 3'd3;
    localparam logic [2:0] OP_AND  = 3'd4;
    localparam logic [2:0] OP_ORR  = 3'd5;
    localparam logic [2:0] OP_XOR  = 3'd6;
    localparam logic [2:0] OP_XNOR = 3'd7;

    localparam int FLAG_NEG  = 3;
    localparam int FLAG_POS  = 2;
    localparam int FLAG_ZERO = 1;
    localparam int FLAG_OVF  = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

endpackage

// File: rtl/sck_sat_counter.sv
// sck_sat_counter: saturating event counter with synchronous clear
//   i_clk   clock
//   i_rst_n asynchronous active-low reset, clears the count
//   i_inc   count one event (ignored once the count is all-ones)
//   i_clr   synchronous clear, wins over i_inc
//   o_cnt   current count
module sck_sat_counter
    import sck_alu_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_cnt
);

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n)
            o_cnt <= '0;
        else if (i_clr)
            o_cnt <= '0;
        else if (i_inc && o_cnt != '1)
            o_cnt <= o_cnt + 1'b1;

endmodule

// File: rtl/sck_alu_sequencer.sv
// sck_alu_sequencer: command/response front end for the 10-bit signed SCK ALU
//   Build option: SCK_ALU_CHAIN_EN enables result chaining via i_cmd_chain.
//   i_clk, i_rst_n                  clock, asynchronous active-low reset
//   i_cmd_valid/o_cmd_ready         command handshake
//   i_cmd_arg0/arg1/oper/chain      command operands, opcode, chain request
//   o_alu_arg0/arg1/oper            registered ALU inputs
//   i_alu_result/i_alu_flag         combinational ALU outputs {NEG,POS,ZERO,OVF}
//   o_rsp_valid/i_rsp_ready         response handshake
//   o_rsp_result/o_rsp_flag         captured ALU result and flags
//   i_clr_stats/o_ovf_cnt           overflow statistic clear and saturating count
module sck_alu_sequencer
    import sck_alu_pkg::*;
#(
    parameter int DATA_W = sck_alu_pkg::DATA_W,
    parameter int CNT_W  = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [DATA_W-1:0] i_cmd_arg0,
    input  logic [DATA_W-1:0] i_cmd_arg1,
    input  logic [2:0]        i_cmd_oper,
    input  logic              i_cmd_chain,
    output logic [DATA_W-1:0] o_alu_arg0,
    output logic [DATA_W-1:0] o_alu_arg1,
    output logic [2:0]        o_alu_oper,
    input  logic [DATA_W-1:0] i_alu_result,
    input  logic [3:0]        i_alu_flag,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_result,
    output logic [3:0]        o_rsp_flag,
    input  logic              i_clr_stats,
    output logic [CNT_W-1:0]  o_ovf_cnt
);

    state_t            state;
    state_t            state_nxt;
    logic              cmd_hs;
    logic              rsp_hs;
    logic              capture;
    logic [DATA_W-1:0] arg0_sel;

    // ready is masked by reset so every output reads 0 while reset is held
    assign o_cmd_ready = (state == IDLE) && i_rst_n;
    assign o_rsp_valid = state == RESP;
    assign cmd_hs      = i_cmd_valid && o_cmd_ready;
    assign rsp_hs      = o_rsp_valid && i_rsp_ready;
    assign capture     = state == ISSUE;

    always_comb
        state_nxt = state == IDLE  ? (cmd_hs ? ISSUE : IDLE) :
                    state == ISSUE ? RESP :
                    (rsp_hs ? IDLE : RESP);

`ifdef SCK_ALU_CHAIN_EN
    logic [DATA_W-1:0] last_result;

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n)
            last_result <= '0;
        else if (capture)
            last_result <= i_alu_result;

    assign arg0_sel = i_cmd_chain ? last_result : i_cmd_arg0;
`else
    logic unused_chain;

    assign unused_chain = i_cmd_chain;
    assign arg0_sel     = i_cmd_arg0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            state        <= IDLE;
            o_alu_arg0   <= '0;
            o_alu_arg1   <= '0;
            o_alu_oper   <= '0;
            o_rsp_result <= '0;
            o_rsp_flag   <= '0;
        end else begin
            state <= state_nxt;
            if (cmd_hs) begin
                o_alu_arg0 <= arg0_sel;
                o_alu_arg1 <= i_cmd_arg1;
                o_alu_oper <= i_cmd_oper;
            end
            if (capture) begin
                o_rsp_result <= i_alu_result;
                o_rsp_flag   <= i_alu_flag;
            end
        end

    sck_sat_counter #(.W(CNT_W)) u_ovf_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_inc   (capture && i_alu_flag[FLAG_OVF]),
        .i_clr   (i_clr_stats),
        .o_cnt   (o_ovf_cnt)
    );

endmodule

// File: tb/tb_sck_alu_sequencer.sv
// tb_sck_alu_sequencer: directed and random checks of sck_alu_sequencer against a behavioural model
module tb_sck_alu_sequencer;

`ifdef SCK_ALU_CHAIN_EN
    localparam bit CHAIN = 1'b1;
`else
    localparam bit CHAIN = 1'b0;
`endif

    localparam logic [2:0] ADD = 3'd0;
    localparam logic [2:0] SUB = 3'd1;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_cmd_valid = 1'b0;
    logic       o_cmd_ready;
    logic [9:0] i_cmd_arg0 = '0;
    logic [9:0] i_cmd_arg1 = '0;
    logic [2:0] i_cmd_oper = '0;
    logic       i_cmd_chain = 1'b0;
    logic [9:0] o_alu_arg0;
    logic [9:0] o_alu_arg1;
    logic [2:0] o_alu_oper;
    logic [9:0] i_alu_result;
    logic [3:0] i_alu_flag;
    logic       o_rsp_valid;
    logic       i_rsp_ready = 1'b0;
    logic [9:0] o_rsp_result;
    logic [3:0] o_rsp_flag;
    logic       i_clr_stats = 1'b0;
    logic [7:0] o_ovf_cnt;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;
    logic [9:0] last_res = '0;
    logic [9:0] p_a, p_b;
    logic [2:0] p_op;

    always #5 i_clk = ~i_clk;

    sck_alu_sequencer #(.DATA_W(10), .CNT_W(8)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_cmd_valid  (i_cmd_valid),
        .o_cmd_ready  (o_cmd_ready),
        .i_cmd_arg0   (i_cmd_arg0),
        .i_cmd_arg1   (i_cmd_arg1),
        .i_cmd_oper   (i_cmd_oper),
        .i_cmd_chain  (i_cmd_chain),
        .o_alu_arg0   (o_alu_arg0),
        .o_alu_arg1   (o_alu_arg1),
        .o_alu_oper   (o_alu_oper),
        .i_alu_result (i_alu_result),
        .i_alu_flag   (i_alu_flag),
        .o_rsp_valid  (o_rsp_valid),
        .i_rsp_ready  (i_rsp_ready),
        .o_rsp_result (o_rsp_result),
        .o_rsp_flag   (o_rsp_flag),
        .i_clr_stats  (i_clr_stats),
        .o_ovf_cnt    (o_ovf_cnt)
    );

    // Behavioural ALU: returns {NEG,POS,ZERO,OVF,result}
    function automatic logic [13:0] alu_fn(input logic signed [9:0] a, input logic signed [9:0] b,
                                           input logic [2:0] op);
        int r;
        logic [9:0] v;
        logic ovf;
        ovf = 1'b0;
        r = 0;
        case (op)
            3'd0: r = int'(a) + int'(b);
            3'd1: r = int'(a) - int'(b);
            default: r = 0;
        endcase
        case (op)
            3'd0, 3'd1: begin v = r[9:0]; ovf = (r > 511) || (r < -512); end
            3'd2: v = a << b[3:0];
            3'd3: v = a >>> b[3:0];
            3'd4: v = a & b;
            3'd5: v = a | b;
            3'd6: v = a ^ b;
            default: v = ~(a ^ b);
        endcase
        return {v[9], !v[9] && v != 0, v == 0, ovf, v};
    endfunction

    assign {i_alu_flag, i_alu_result} = alu_fn(o_alu_arg0, o_alu_arg1, o_alu_oper);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one command and follow it through to its response handshake.
    // pend: present the p_* command during backpressure; it must stay unconsumed.
    task automatic run_cmd(input logic [9:0] a, input logic [9:0] b, input logic [2:0] op,
                           input bit ch, input int hold, input bit clr_cap, input bit pend);
        logic [9:0] ea;
        logic [13:0] r;
        int n;
        ea = (CHAIN && ch) ? last_res : a;
        r = alu_fn(ea, b, op);
        i_cmd_valid = 1'b1;
        i_cmd_arg0 = a;
        i_cmd_arg1 = b;
        i_cmd_oper = op;
        i_cmd_chain = ch;
        n = 0;
        while (!o_cmd_ready && n < 20) begin
            @(negedge i_clk);
            n++;
        end
        chk("cmd_accept_timeout", 32'(n < 20), 1);
        @(negedge i_clk);
        i_cmd_valid = 1'b0;
        chk("alu_arg0", o_alu_arg0, ea);
        chk("alu_arg1", o_alu_arg1, b);
        chk("alu_oper", o_alu_oper, op);
        chk("issue_rsp_valid", o_rsp_valid, 0);
        chk("issue_cmd_ready", o_cmd_ready, 0);
        i_clr_stats = clr_cap;
        @(negedge i_clk);
        i_clr_stats = 1'b0;
        exp_cnt = clr_cap ? 0 : (r[10] && exp_cnt < 255) ? exp_cnt + 1 : exp_cnt;
        last_res = r[9:0];
        chk("rsp_valid", o_rsp_valid, 1);
        chk("rsp_result", o_rsp_result, r[9:0]);
        chk("rsp_flag", o_rsp_flag, r[13:10]);
        chk("ovf_cnt", o_ovf_cnt, exp_cnt);
        if (pend) begin
            i_cmd_valid = 1'b1;
            i_cmd_arg0 = p_a;
            i_cmd_arg1 = p_b;
            i_cmd_oper = p_op;
            i_cmd_chain = 1'b0;
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge i_clk);
            chk("hold_valid", o_rsp_valid, 1);
            chk("hold_result", o_rsp_result, r[9:0]);
            chk("hold_flag", o_rsp_flag, r[13:10]);
            chk("hold_cmd_ready", o_cmd_ready, 0);
            chk("hold_alu_arg0", o_alu_arg0, ea);
        end
        i_rsp_ready = 1'b1;
        @(negedge i_clk);
        i_rsp_ready = 1'b0;
        chk("post_rsp_valid", o_rsp_valid, 0);
        chk("post_cmd_ready", o_cmd_ready, 1);
        chk("post_alu_arg0", o_alu_arg0, ea);
    endtask

    initial begin
        #1;
        chk("rst_cmd_ready", o_cmd_ready, 0);
        chk("rst_rsp_valid", o_rsp_valid, 0);
        chk("rst_alu_arg0", o_alu_arg0, 0);
        chk("rst_rsp_result", o_rsp_result, 0);
        chk("rst_ovf_cnt", o_ovf_cnt, 0);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        chk("rel_cmd_ready", o_cmd_ready, 1);
        chk("rel_rsp_valid", o_rsp_valid, 0);

        run_cmd(10'd100, 10'd50, ADD, 1'b0, 0, 1'b0, 1'b0);
        chk("add_150", o_rsp_result, 10'd150);
        run_cmd(10'd300, 10'd300, ADD, 1'b0, 0, 1'b0, 1'b0);
        chk("ovf_result", o_rsp_result, 10'h258);
        chk("ovf_cnt_1", o_ovf_cnt, 1);

        p_a = 10'd10;
        p_b = 10'd20;
        p_op = ADD;
        run_cmd(10'd5, 10'd5, SUB, 1'b0, 5, 1'b0, 1'b1);
        run_cmd(p_a, p_b, p_op, 1'b0, 0, 1'b0, 1'b0);
        chk("add_30", o_rsp_result, 10'd30);
        run_cmd(10'd7, 10'd5, ADD, 1'b1, 0, 1'b0, 1'b0);
        chk("chain_result", o_rsp_result, CHAIN ? 10'd35 : 10'd12);

        for (int i = 0; i < 40; i++)
            run_cmd(10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)),
                    3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 2), 1'b0, 1'b0);

        i_clr_stats = 1'b1;
        @(negedge i_clk);
        i_clr_stats = 1'b0;
        exp_cnt = 0;
        chk("clr_idle", o_ovf_cnt, 0);

        for (int i = 0; i < 256; i++)
            run_cmd(10'($urandom_range(300, 511)), 10'($urandom_range(300, 511)), ADD,
                    1'b0, 0, 1'b0, 1'b0);
        chk("sat_255", o_ovf_cnt, 255);
        run_cmd(10'd400, 10'd400, ADD, 1'b0, 0, 1'b1, 1'b0);
        chk("clr_priority", o_ovf_cnt, 0);
        run_cmd(10'd511, 10'd1, ADD, 1'b0, 0, 1'b0, 1'b0);
        chk("cnt_after_clr", o_ovf_cnt, 1);

        i_cmd_valid = 1'b1;
        i_cmd_arg0 = 10'd300;
        i_cmd_arg1 = 10'd300;
        i_cmd_oper = ADD;
        i_cmd_chain = 1'b0;
        @(negedge i_clk);
        i_cmd_valid = 1'b0;
        chk("abort_issue_arg0", o_alu_arg0, 10'd300);
        #1 i_rst_n = 1'b0;
        #1;
        chk("abort_cmd_ready", o_cmd_ready, 0);
        chk("abort_rsp_valid", o_rsp_valid, 0);
        chk("abort_alu_arg0", o_alu_arg0, 0);
        chk("abort_alu_arg1", o_alu_arg1, 0);
        chk("abort_rsp_result", o_rsp_result, 0);
        chk("abort_rsp_flag", o_rsp_flag, 0);
        chk("abort_ovf_cnt", o_ovf_cnt, 0);
        exp_cnt = 0;
        last_res = '0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge i_clk);
            chk("abort_no_rsp", o_rsp_valid, 0);
            chk("abort_ready", o_cmd_ready, 1);
        end
        run_cmd(10'd55, 10'd5, ADD, 1'b1, 1, 1'b0, 1'b0);
        chk("chain_after_rst", o_rsp_result, CHAIN ? 10'd5 : 10'd60);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
